// File: rtl/sound_cmd_fifo_if.sv
// 68k-to-Z80 sound command mailbox signals: strobes and data in, queued byte and status out.
interface sound_cmd_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 2
);
  logic                  nSOUND_WR;
  logic [7:0]            M68K_DATA;
  logic                  Z80_nLATCH_RD;
  logic                  Z80_nACK_WR;
  logic [7:0]            Z80_DOUT;
  logic                  Z80_nIRQ;
  logic [DEPTH_LOG2:0]   FIFO_COUNT;
  logic                  OVERRUN;

  modport master (
    output nSOUND_WR, M68K_DATA, Z80_nLATCH_RD, Z80_nACK_WR,
    input  Z80_DOUT, Z80_nIRQ, FIFO_COUNT, OVERRUN
  );

  modport slave (
    input  nSOUND_WR, M68K_DATA, Z80_nLATCH_RD, Z80_nACK_WR,
    output Z80_DOUT, Z80_nIRQ, FIFO_COUNT, OVERRUN
  );
endinterface

// File: rtl/sound_cmd_fifo.sv
// Sound command FIFO: edge-detected 68k writes queue bytes for the Z80, which pops them
// show-ahead, sees a pending-command IRQ, and acknowledges dropped-write overruns.
module sound_cmd_fifo #(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic            CLK,
  input  logic            nRESET,
  sound_cmd_fifo_if.slave bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic          wr_s1_q, wr_s2_q, rd_s1_q, rd_s2_q, ack_s1_q, ack_s2_q;
  logic [7:0]    data_q;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    last_q, last_d;
  logic          overrun_q, overrun_d;
  logic          irq_n_q, irq_n_d;
  logic          wr_ev, rd_ev, ack_ev, do_push, do_pop;

  always_comb begin
    wr_ev  = wr_s2_q & ~wr_s1_q;
    rd_ev  = rd_s2_q & ~rd_s1_q;
    ack_ev = ack_s2_q & ~ack_s1_q;
    do_pop = rd_ev && (count_q != '0);
    // A pop in the same cycle frees the slot, so a write into a full FIFO is still accepted.
    do_push = wr_ev && ((count_q != FULL) || do_pop);

    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    last_d    = last_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (do_push) begin
      mem_d[wptr_q] = data_q;
      wptr_d        = wptr_q + PW'(1);
    end
    if (do_pop) begin
      last_d = mem_q[rptr_q];
      rptr_d = rptr_q + PW'(1);
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (wr_ev && !do_push) overrun_d = 1'b1;
    else if (ack_ev)       overrun_d = 1'b0;

    irq_n_d = (count_d == '0);
  end

  always_ff @(posedge CLK) begin
    data_q   <= bus.M68K_DATA;
    wr_s1_q  <= bus.nSOUND_WR;
    rd_s1_q  <= bus.Z80_nLATCH_RD;
    ack_s1_q <= bus.Z80_nACK_WR;
    if (!nRESET) begin
      // Both stages track the live pin so a strobe held low through reset is not an edge.
      wr_s2_q   <= bus.nSOUND_WR;
      rd_s2_q   <= bus.Z80_nLATCH_RD;
      ack_s2_q  <= bus.Z80_nACK_WR;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      last_q    <= '0;
      overrun_q <= 1'b0;
      irq_n_q   <= 1'b1;
    end else begin
      wr_s2_q   <= wr_s1_q;
      rd_s2_q   <= rd_s1_q;
      ack_s2_q  <= ack_s1_q;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
      irq_n_q   <= irq_n_d;
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign bus.Z80_DOUT   = (count_q != '0) ? mem_q[rptr_q] : last_q;
  assign bus.Z80_nIRQ   = irq_n_q;
  assign bus.FIFO_COUNT = count_q;
  assign bus.OVERRUN    = overrun_q;
endmodule
